// File: rtl/sample_frame_buffer.sv
// Ping-pong frame buffer between the I2S receiver and the FFT core: it collects truncated
// mic samples into two FRAME_LEN banks and streams each completed bank out over valid/ready.
module sample_frame_buffer #(
  parameter int FRAME_LEN = 256,
  parameter int ADDR_W    = 8,
  parameter int IN_W      = 24,
  parameter int OUT_W     = 16
) (
  input  logic              clk_25m,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_FETCH  = 2'b01;
  localparam logic [1:0] S_STREAM = 2'b10;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

  logic [OUT_W-1:0]  r_ram [0:2*FRAME_LEN-1];
  logic [OUT_W-1:0]  r_ram_q;

  logic              r_wr_bank;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [1:0]        r_bank_full;
  logic              r_rd_bank;
  logic [ADDR_W-1:0] r_rd_idx;
  logic [1:0]        r_state;
  logic              r_overflow;

  logic              w_wr_en;
  logic              w_drop;
  logic              w_wr_last;
  logic              w_streaming;
  logic              w_accept;
  logic              w_release;
  logic [ADDR_W-1:0] w_rd_idx_next;
  logic [ADDR_W:0]   w_rd_addr;
  logic [ADDR_W:0]   w_wr_addr;
  logic [OUT_W-1:0]  w_wr_data;
  logic              w_unused_in;

  assign w_wr_en   = in_valid && !r_bank_full[r_wr_bank];
  assign w_drop    = in_valid &&  r_bank_full[r_wr_bank];
  assign w_wr_last = w_wr_en && (r_wr_ptr == LAST_IDX);
  assign w_wr_addr = {r_wr_bank, r_wr_ptr};
  assign w_wr_data = in_data[IN_W-1 -: OUT_W];
  // Low-order input bits are discarded by truncation.
  assign w_unused_in = ^in_data;

  assign w_streaming = (r_state == S_STREAM);
  assign w_accept    = w_streaming && out_ready;
  assign w_release   = w_accept && (r_rd_idx == LAST_IDX);

  // The read address already points at the word that will be current after this edge,
  // so the registered RAM output tracks the presented index with no bubble.
  assign w_rd_idx_next = w_accept ? (r_rd_idx + ONE_IDX) : r_rd_idx;
  assign w_rd_addr     = {r_rd_bank, w_rd_idx_next};

  always_ff @(posedge clk_25m) begin
    if (w_wr_en) begin
      r_ram[w_wr_addr] <= w_wr_data;
    end
    r_ram_q <= r_ram[w_rd_addr];
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_wr_ptr  <= '0;
    end else if (w_wr_en) begin
      r_wr_ptr <= r_wr_ptr + ONE_IDX;
      if (w_wr_last) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // A bank is filled and released by different sides; both can never target the same bank at once.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank_full
      always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
          r_bank_full[gi] <= 1'b0;
        end else if (w_wr_last && (r_wr_bank == 1'(gi))) begin
          r_bank_full[gi] <= 1'b1;
        end else if (w_release && (r_rd_bank == 1'(gi))) begin
          r_bank_full[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rd_bank <= 1'b0;
      r_rd_idx  <= '0;
    end else begin
      r_rd_idx <= w_rd_idx_next;
      case (r_state)
        S_IDLE: begin
          if (r_bank_full[r_rd_bank]) begin
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (w_release) begin
            r_state   <= S_IDLE;
            r_rd_bank <= ~r_rd_bank;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The RAM output register has no reset, so it is masked to keep outputs at 0 outside a frame.
  assign out_valid = w_streaming;
  assign out_data  = w_streaming ? r_ram_q : '0;
  assign out_index = r_rd_idx;
  assign out_last  = w_streaming && (r_rd_idx == LAST_IDX);
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Bench for sample_frame_buffer: queue-based frame model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_sample_frame_buffer;

  localparam int FL = 8;
  localparam int AW = 3;
  localparam int IW = 24;
  localparam int OW = 16;

  logic          clk_25m = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          overflow_clr = 1'b0;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic          overflow;

  always #20 clk_25m = ~clk_25m;

  sample_frame_buffer #(.FRAME_LEN(FL), .ADDR_W(AW), .IN_W(IW), .OUT_W(OW)) dut (
    .clk_25m(clk_25m), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .overflow(overflow),
    .overflow_clr(overflow_clr));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words of completed frames awaiting delivery, the frame being filled,
  // and the number of banks holding a completed frame not yet fully accepted.
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] build_q[$];
  int            pending = 0;
  int            rd_pos = 0;
  logic          m_ovf = 1'b0;
  logic [OW-1:0] acc_log[$];
  int            last_cnt = 0;
  logic          prev_hold = 1'b0;
  logic [OW-1:0] prev_data;
  logic [AW-1:0] prev_idx;
  logic          prev_last;

  always @(negedge clk_25m) begin
    int pend_pre;
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_index", 32'(out_index), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_overflow", 32'(overflow), 0);
      exp_q.delete();
      build_q.delete();
      pending = 0;
      rd_pos = 0;
      m_ovf = 1'b0;
      prev_hold = 1'b0;
    end else begin
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (out_valid) chk("frame_available", 32'(exp_q.size() > 0), 1);
      if (prev_hold) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
        chk("hold_index", 32'(out_index), 32'(prev_idx));
        chk("hold_last", 32'(out_last), 32'(prev_last));
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_idx  = out_index;
      prev_last = out_last;
      pend_pre = pending;
      // Effects of the coming rising edge, all decided from pre-edge state.
      if (out_valid && out_ready && exp_q.size() > 0) begin
        chk("out_data", 32'(out_data), 32'(exp_q[0]));
        chk("out_index", 32'(out_index), rd_pos);
        chk("out_last", 32'(out_last), 32'(rd_pos == FL - 1));
        acc_log.push_back(out_data);
        if (out_last) last_cnt++;
        void'(exp_q.pop_front());
        rd_pos++;
        if (rd_pos == FL) begin
          rd_pos = 0;
          pending--;
        end
      end
      if (in_valid && pend_pre == 2) begin
        m_ovf = 1'b1;
      end else begin
        if (overflow_clr) m_ovf = 1'b0;
        if (in_valid) begin
          build_q.push_back(in_data[IW-1 -: OW]);
          if (build_q.size() == FL) begin
            foreach (build_q[i]) exp_q.push_back(build_q[i]);
            build_q.delete();
            pending++;
          end
        end
      end
    end
  end

  task automatic send(input logic [IW-1:0] d);
    @(posedge clk_25m); #1;
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk_25m); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk_25m); #1;
      n++;
    end
    chk(name, 32'((exp_q.size() == 0) && !out_valid), 1);
  endtask

  task automatic clear_log();
    acc_log.delete();
    last_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk_25m);
    #5 rst_n = 1'b1;
    @(negedge clk_25m);
    chk("post_reset_valid", 32'(out_valid), 0);
    chk("post_reset_overflow", 32'(overflow), 0);

    // Single frame with spaced samples, exact output latency.
    out_ready = 1'b1;
    clear_log();
    for (int k = 1; k <= FL; k++) begin
      repeat (62) @(posedge clk_25m);
      send(24'h000100 * k + 24'h0000AB);
    end
    @(negedge clk_25m);
    chk("latency_edge0", 32'(out_valid), 0);
    @(posedge clk_25m); @(negedge clk_25m);
    chk("latency_edge1", 32'(out_valid), 0);
    @(posedge clk_25m); @(negedge clk_25m);
    chk("latency_edge2", 32'(out_valid), 1);
    drain(50, "single_drain");
    chk("single_count", acc_log.size(), FL);
    for (int i = 0; i < FL && i < acc_log.size(); i++) chk("single_value", 32'(acc_log[i]), i + 1);
    chk("single_last_cnt", last_cnt, 1);

    // Backpressure with random out_ready.
    clear_log();
    out_ready = 1'b0;
    for (int k = 0; k < FL; k++) send(24'h000100 * (k + 'h20));
    for (int c = 0; c < 80; c++) begin
      @(posedge clk_25m); #1;
      out_ready = 1'($urandom_range(0, 1));
    end
    drain(50, "bp_drain");
    chk("bp_count", acc_log.size(), FL);
    for (int i = 0; i < FL && i < acc_log.size(); i++) chk("bp_value", 32'(acc_log[i]), i + 'h20);

    // Overflow: both banks fill with no consumer, 17th sample is dropped.
    clear_log();
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) send(24'h000100 * k);
    @(negedge clk_25m);
    chk("ovf_before_17th", 32'(overflow), 0);
    send(24'h000100 * 16);
    @(negedge clk_25m);
    chk("ovf_after_17th", 32'(overflow), 1);
    drain(100, "ovf_drain");
    chk("ovf_count", acc_log.size(), 2 * FL);
    for (int i = 0; i < 2 * FL && i < acc_log.size(); i++) chk("ovf_value", 32'(acc_log[i]), i);
    chk("ovf_last_cnt", last_cnt, 2);
    @(posedge clk_25m); #1 overflow_clr = 1'b1;
    @(posedge clk_25m); #1 overflow_clr = 1'b0;
    @(negedge clk_25m);
    chk("ovf_cleared", 32'(overflow), 0);

    // Back-to-back input: 16 samples on consecutive cycles.
    clear_log();
    out_ready = 1'b1;
    @(posedge clk_25m); #1;
    for (int k = 0; k < 2 * FL; k++) begin
      in_valid = 1'b1;
      in_data  = 24'($urandom);
      @(posedge clk_25m); #1;
    end
    in_valid = 1'b0;
    drain(60, "b2b_drain");
    chk("b2b_count", acc_log.size(), 2 * FL);
    chk("b2b_last_cnt", last_cnt, 2);
    chk("b2b_no_overflow", 32'(overflow), 0);

    // Sign-preserving truncation.
    clear_log();
    send(24'hFFFF80);
    send(24'h7FFFFF);
    send(24'h800000);
    for (int k = 0; k < FL - 3; k++) send(24'h000000);
    drain(50, "sign_drain");
    chk("sign_count", acc_log.size(), FL);
    if (acc_log.size() >= 3) begin
      chk("sign_neg", 32'(acc_log[0]), 32'h0000FFFF);
      chk("sign_max", 32'(acc_log[1]), 32'h00007FFF);
      chk("sign_min", 32'(acc_log[2]), 32'h00008000);
    end

    // Reset while streaming and with a partial frame in the other bank.
    out_ready = 1'b1;
    for (int k = 0; k < FL; k++) send(24'h001100);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk_25m); #1;
      n++;
    end
    chk("pre_rst_streaming", 32'(out_valid), 1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(24'h003300);
    @(posedge clk_25m); #5 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_data", 32'(out_data), 0);
    chk("async_rst_last", 32'(out_last), 0);
    repeat (2) @(negedge clk_25m);
    #2 rst_n = 1'b1;
    clear_log();
    out_ready = 1'b1;
    for (int k = 0; k < FL; k++) send(24'h000100 * (k + 'h40));
    drain(50, "after_rst_drain");
    chk("after_rst_count", acc_log.size(), FL);
    if (acc_log.size() > 0) chk("after_rst_first", 32'(acc_log[0]), 'h40);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_25m); #1;
      in_valid     = ($urandom_range(0, 3) == 0);
      in_data      = 24'($urandom);
      out_ready    = ($urandom_range(0, 99) < 60);
      overflow_clr = ($urandom_range(0, 49) == 0);
    end
    @(posedge clk_25m); #1;
    in_valid = 1'b0;
    overflow_clr = 1'b0;
    drain(200, "random_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
